// File: rtl/fwd_hazard_unit_pkg.sv
// ----------------------------------------------------------------------------
// fwd_pkg
// Shared types and helpers for the forwarding / hazard unit.
//   stage_entry_t : one tracked in-flight instruction (valid, we, is_load, rd)
//   SEL_RF        : bypass select value meaning "read the register file"
//   sel_width()   : select width for a given tracking depth
// Optional feature macro used by the unit: FWD_MULTICYCLE_EN
// ----------------------------------------------------------------------------
package fwd_pkg;

    // rd is stored at a fixed maximum width so the struct does not depend on
    // the REG_AW parameter; narrower indices are zero-extended on entry.
    localparam int REG_AW_MAX = 8;
    localparam int SEL_RF     = 0;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  is_load;
        logic [REG_AW_MAX-1:0] rd;
    } stage_entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ----------------------------------------------------------------------------
// fwd_hazard_unit_if
// Decode-side bundle between the decoder (master) and the forwarding/hazard
// unit (slave).
//   master drives : pipe_en, flush, issue_valid, issue_we, issue_is_load,
//                   issue_rd, issue_rs, issue_mc, mc_done, mc_done_rd
//   slave drives  : sel (per-source bypass select), stall
// issue_mc / mc_done / mc_done_rd only matter when FWD_MULTICYCLE_EN is set.
// ----------------------------------------------------------------------------
interface fwd_hazard_unit_if
    import fwd_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int REG_AW    = 5
);
    localparam int SEL_W = sel_width(FWD_DEPTH);

    logic                      pipe_en;
    logic                      flush;
    logic                      issue_valid;
    logic                      issue_we;
    logic                      issue_is_load;
    logic [REG_AW-1:0]         issue_rd;
    logic [NUM_SRC*REG_AW-1:0] issue_rs;
    logic                      issue_mc;
    logic                      mc_done;
    logic [REG_AW-1:0]         mc_done_rd;
    logic [NUM_SRC*SEL_W-1:0]  sel;
    logic                      stall;

    modport master (
        output pipe_en, flush, issue_valid, issue_we, issue_is_load,
               issue_rd, issue_rs, issue_mc, mc_done, mc_done_rd,
        input  sel, stall
    );

    modport slave (
        input  pipe_en, flush, issue_valid, issue_we, issue_is_load,
               issue_rd, issue_rs, issue_mc, mc_done, mc_done_rd,
        output sel, stall
    );

endinterface

// File: rtl/fwd_hazard_unit_scoreboard.sv
// ----------------------------------------------------------------------------
// fwd_scoreboard
// Busy bitmap for registers owned by the multicycle unit (mul/div).
//   clk, rst_n        : clock, async active-low reset (all bits cleared)
//   set_en, set_rd    : mark set_rd busy (x0 is never marked)
//   clr_en, clr_rd    : multicycle write-back frees clr_rd
//   rs_i              : NUM_SRC packed source indices to look up
//   rs_busy_o         : per-source busy flag (x0 never busy)
//   rd_i, rd_busy_o   : destination lookup for WAW
// Lookups read the registered bitmap, so a register freed this cycle is seen
// as free on the following cycle. A set and clear of the same rd in the same
// cycle leaves the bit set.
// ----------------------------------------------------------------------------
module fwd_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      set_en,
    input  logic [REG_AW-1:0]         set_rd,
    input  logic                      clr_en,
    input  logic [REG_AW-1:0]         clr_rd,
    input  logic [NUM_SRC*REG_AW-1:0] rs_i,
    output logic [NUM_SRC-1:0]        rs_busy_o,
    input  logic [REG_AW-1:0]         rd_i,
    output logic                      rd_busy_o
);
    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0] busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            if (clr_en)
                busy_q[clr_rd] <= 1'b0;
            // later assignment wins: set overrides a same-cycle clear
            if (set_en && (set_rd != '0))
                busy_q[set_rd] <= 1'b1;
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_lookup
        logic [REG_AW-1:0] rs;
        assign rs           = rs_i[s*REG_AW +: REG_AW];
        assign rs_busy_o[s] = (rs != '0) && busy_q[rs];
    end

    assign rd_busy_o = (rd_i != '0) && busy_q[rd_i];

endmodule

// File: rtl/fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding and hazard unit for the integer pipeline. Tracks the destination
// of in-flight instructions over FWD_DEPTH stages after decode and returns a
// bypass select per source operand plus a decode stall for load-use hazards.
//   clk   : core clock
//   rst_n : async active-low reset, clears all tracked state
//   bus   : fwd_hazard_unit_if.slave (issue inputs, sel / stall outputs)
// sel[s] = 0 reads the register file, k selects stage k (1 = EX output).
// Optional macro FWD_MULTICYCLE_EN adds a busy scoreboard for the multicycle
// unit and interlocks RAW/WAW against it; without it issue_mc, mc_done and
// mc_done_rd are ignored and mc instructions are tracked as ordinary entries.
// ----------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int REG_AW    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_hazard_unit_if.slave   bus
);
    localparam int SEL_W = sel_width(FWD_DEPTH);

    stage_entry_t stage_q [1:FWD_DEPTH];
    stage_entry_t stage_d [1:FWD_DEPTH];
    stage_entry_t issue_entry;

    logic [NUM_SRC-1:0] lu_hit;
    logic               mc_hazard;
    logic               stall;
    logic               accept;
    logic               enter;

    assign issue_entry.valid   = 1'b1;
    assign issue_entry.we      = bus.issue_we;
    assign issue_entry.is_load = bus.issue_is_load;
    assign issue_entry.rd      = REG_AW_MAX'(bus.issue_rd);

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [REG_AW-1:0]     rs;
        logic [REG_AW_MAX-1:0] rs_ext;
        logic [SEL_W-1:0]      sel_s;

        assign rs     = bus.issue_rs[s*REG_AW +: REG_AW];
        assign rs_ext = REG_AW_MAX'(rs);

        // walk oldest to youngest so the youngest matching stage is kept
        always_comb begin
            sel_s = SEL_W'(SEL_RF);
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if ((rs != '0) && stage_q[k].valid && stage_q[k].we &&
                    (stage_q[k].rd == rs_ext))
                    sel_s = SEL_W'(k);
            end
        end

        // a load still in stage 1 has no data yet
        assign lu_hit[s] = (rs != '0) && stage_q[1].valid && stage_q[1].we &&
                           stage_q[1].is_load && (stage_q[1].rd == rs_ext);

        assign bus.sel[s*SEL_W +: SEL_W] = sel_s;
    end

`ifdef FWD_MULTICYCLE_EN
    logic [NUM_SRC-1:0] rs_busy;
    logic               rd_busy;

    fwd_scoreboard #(
        .NUM_SRC (NUM_SRC),
        .REG_AW  (REG_AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (accept && bus.issue_mc && bus.issue_we),
        .set_rd    (bus.issue_rd),
        .clr_en    (bus.mc_done),
        .clr_rd    (bus.mc_done_rd),
        .rs_i      (bus.issue_rs),
        .rs_busy_o (rs_busy),
        .rd_i      (bus.issue_rd),
        .rd_busy_o (rd_busy)
    );

    assign mc_hazard = (|rs_busy) || (bus.issue_we && rd_busy);
    // multicycle results come back through the scoreboard, not the stages
    assign enter     = accept && !bus.issue_mc;
`else
    logic unused_mc;
    assign unused_mc = ^{bus.issue_mc, bus.mc_done, bus.mc_done_rd};
    assign mc_hazard = 1'b0;
    assign enter     = accept;
`endif

    assign stall     = bus.issue_valid && ((|lu_hit) || mc_hazard);
    assign bus.stall = stall;
    // flush squashes decode even when it is also stalling
    assign accept    = bus.pipe_en && bus.issue_valid && !stall && !bus.flush;

    always_comb begin
        for (int k = 1; k <= FWD_DEPTH; k++)
            stage_d[k] = stage_q[k];
        if (bus.pipe_en) begin
            for (int k = FWD_DEPTH; k >= 2; k--)
                stage_d[k] = stage_q[k-1];
            stage_d[1] = enter ? issue_entry : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= FWD_DEPTH; k++)
                stage_q[k] <= '0;
        end else begin
            for (int k = 1; k <= FWD_DEPTH; k++)
                stage_q[k] <= stage_d[k];
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam int NS = 2;
    localparam int D  = 2;
    localparam int AW = 5;
    localparam int SW = sel_width(D);
`ifdef FWD_MULTICYCLE_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.NUM_SRC(NS), .FWD_DEPTH(D), .REG_AW(AW)) bus ();

    fwd_hazard_unit #(.NUM_SRC(NS), .FWD_DEPTH(D), .REG_AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // reference model: list of in-flight writers, index 1 = youngest
    bit m_valid [1:D];
    bit m_we    [1:D];
    bit m_ld    [1:D];
    int m_rd    [1:D];
    bit busy    [0:(2**AW)-1];

    int npass = 0;
    int ntot  = 0;

    function automatic void m_clear();
        for (int k = 1; k <= D; k++) begin
            m_valid[k] = 0; m_we[k] = 0; m_ld[k] = 0; m_rd[k] = 0;
        end
        for (int r = 0; r < 2**AW; r++) busy[r] = 0;
    endfunction

    function automatic int rs_of(int s);
        return int'(bus.issue_rs[s*AW +: AW]);
    endfunction

    function automatic int m_sel(int rs);
        if (rs == 0) return 0;
        for (int k = 1; k <= D; k++)
            if (m_valid[k] && m_we[k] && m_rd[k] == rs) return k;
        return 0;
    endfunction

    function automatic bit m_stall();
        bit h = 0;
        if (!bus.issue_valid) return 0;
        for (int s = 0; s < NS; s++) begin
            int rs = rs_of(s);
            if (rs != 0 && m_valid[1] && m_we[1] && m_ld[1] && m_rd[1] == rs) h = 1;
            if (MC && rs != 0 && busy[rs]) h = 1;
        end
        if (MC && bus.issue_we && bus.issue_rd != 0 && busy[bus.issue_rd]) h = 1;
        return h;
    endfunction

    function automatic void model_step();
        bit st, acc;
        if (!rst_n) begin
            m_clear();
            return;
        end
        st  = m_stall();
        acc = bus.pipe_en && bus.issue_valid && !st && !bus.flush;
        if (MC && bus.mc_done) busy[bus.mc_done_rd] = 0;
        if (MC && acc && bus.issue_mc && bus.issue_we && bus.issue_rd != 0)
            busy[bus.issue_rd] = 1;
        if (bus.pipe_en) begin
            for (int k = D; k >= 2; k--) begin
                m_valid[k] = m_valid[k-1]; m_we[k] = m_we[k-1];
                m_ld[k] = m_ld[k-1]; m_rd[k] = m_rd[k-1];
            end
            m_valid[1] = acc && !(MC && bus.issue_mc);
            m_we[1]    = m_valid[1] && bus.issue_we;
            m_ld[1]    = m_valid[1] && bus.issue_is_load;
            m_rd[1]    = m_valid[1] ? int'(bus.issue_rd) : 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input int e0, input int e1, input int es);
        for (int s = 0; s < NS; s++)
            chk($sformatf("%s.sel%0d", tag, s), 32'(bus.sel[s*SW +: SW]), 32'(m_sel(rs_of(s))));
        chk($sformatf("%s.stall", tag), 32'(bus.stall), 32'(m_stall()));
        if (e0 >= 0) chk($sformatf("%s.exp_sel0", tag), 32'(bus.sel[0 +: SW]), 32'(e0));
        if (e1 >= 0) chk($sformatf("%s.exp_sel1", tag), 32'(bus.sel[SW +: SW]), 32'(e1));
        if (es >= 0) chk($sformatf("%s.exp_stall", tag), 32'(bus.stall), 32'(es));
    endtask

    // check between edges, then let one clock edge happen
    task automatic tick(input string tag, input int e0 = -1, input int e1 = -1, input int es = -1);
        @(negedge clk);
        check_all(tag, e0, e1, es);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic peek(input string tag, input int e0, input int e1, input int es);
        #1;
        check_all(tag, e0, e1, es);
    endtask

    task automatic issue(input bit v, input bit we, input bit ld, input int rd,
                         input int rs0, input int rs1, input bit mc = 0);
        bus.issue_valid   = v;
        bus.issue_we      = we;
        bus.issue_is_load = ld;
        bus.issue_rd      = AW'(rd);
        bus.issue_rs      = {AW'(rs1), AW'(rs0)};
        bus.issue_mc      = mc;
    endtask

    task automatic drain();
        issue(0, 0, 0, 0, 0, 0);
        bus.pipe_en = 1; bus.flush = 0; bus.mc_done = 0;
        repeat (D) tick("drain");
    endtask

    initial begin
        m_clear();
        bus.pipe_en = 1; bus.flush = 0; bus.mc_done = 0; bus.mc_done_rd = '0;
        issue(1, 1, 0, 3, 5, 7);

        // reset state
        peek("rst", 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1;
        drain();

        // mid-traffic reset with both stages full
        issue(1, 1, 0, 5, 1, 2); tick("add5");
        issue(1, 1, 1, 7, 0, 0); tick("lw7");
        issue(1, 1, 0, 8, 5, 7);
        peek("pre_rst", 2, 1, 1);
        rst_n = 0; m_clear();
        peek("rst_mid", 0, 0, 0);
        tick("rst_hold", 0, 0, 0);
        rst_n = 1;
        tick("post_rst", 0, 0, 0);
        drain();

        // basic forwarding from stage 1, stage 2, and x0
        issue(1, 1, 0, 5, 1, 2); tick("add5");
        issue(1, 0, 0, 0, 5, 0); tick("fwd1", 1, 0, 0);
        drain();
        issue(1, 1, 0, 5, 1, 2); tick("add5");
        issue(0, 0, 0, 0, 0, 0); tick("bubble");
        issue(1, 0, 0, 0, 5, 0); tick("fwd2", 2, 0, 0);
        issue(1, 1, 0, 0, 0, 0); tick("rs_x0", 0, 0, 0);
        drain();

        // youngest writer wins
        issue(1, 1, 0, 5, 0, 0); tick("add5a");
        issue(1, 1, 0, 5, 0, 0); tick("add5b");
        issue(1, 0, 0, 0, 5, 5); tick("young", 1, 1, 0);
        drain();

        // load-use: one stall, then forward from stage 2
        issue(1, 1, 1, 7, 0, 0); tick("lw7");
        issue(1, 1, 0, 8, 1, 7); tick("lu_stall", 0, 1, 1);
        tick("lu_go", 0, 2, 0);
        drain();

        // load followed by held pipe and flush
        issue(1, 1, 1, 7, 0, 0); tick("lw7");
        issue(1, 1, 0, 8, 1, 7);
        bus.pipe_en = 0;
        tick("hold1", 0, 1, 1);
        tick("hold2", 0, 1, 1);
        bus.pipe_en = 1; bus.flush = 1;
        tick("fl_stall", 0, 1, 1);
        bus.flush = 0;
        tick("fl_after", 0, 2, 0);
        tick("drop", 0, 0, 0);
        drain();

`ifdef FWD_MULTICYCLE_EN
        issue(1, 1, 0, 9, 0, 0, 1); tick("mul9");
        issue(1, 1, 0, 10, 9, 0);
        tick("mc_raw1", 0, 0, 1);
        tick("mc_raw2", 0, 0, 1);
        bus.mc_done = 1; bus.mc_done_rd = AW'(9);
        tick("mc_done", 0, 0, 1);
        bus.mc_done = 0;
        tick("mc_go", 0, 0, 0);
        issue(1, 1, 0, 9, 0, 0, 1); tick("mul9b");
        issue(1, 1, 0, 9, 0, 0);
        tick("waw", 0, 0, 1);
        bus.mc_done = 1; bus.mc_done_rd = AW'(9);
        tick("waw_done", 0, 0, 1);
        bus.mc_done = 0;
        tick("waw_go", 0, 0, 0);
        drain();
`else
        issue(1, 1, 0, 9, 0, 0, 1); tick("mul9");
        issue(1, 1, 0, 10, 9, 0); tick("mc_off", 1, 0, 0);
        drain();
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(3) != 0, $urandom_range(1), $urandom_range(2) == 0,
                  $urandom_range(3), $urandom_range(3), $urandom_range(3),
                  $urandom_range(3) == 0);
            bus.pipe_en    = $urandom_range(4) != 0;
            bus.flush      = $urandom_range(9) == 0;
            bus.mc_done    = $urandom_range(2) == 0;
            bus.mc_done_rd = AW'($urandom_range(3));
            if ($urandom_range(63) == 0) begin
                rst_n = 0; m_clear();
                tick("rnd_rst");
                rst_n = 1;
            end else begin
                tick("rnd");
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
